enc_rr_arbiter3: RTL and testbench
==================================

Name: enc_rr_arbiter3

Overview:
- Round-robin arbiter that shares one downstream resource among three requesters.
- Reports the winner one-hot and as a 2-bit encoded index, matching the 3-to-2 encoder convention used elsewhere in the design.
- Adds grant hold, explicit release and a hold timeout, so no requester can monopolise the resource.
- Sits between the three request sources and the shared datapath slot; gnt_idx drives the datapath mux select.

Parameters:
- MAX_HOLD, 15: maximum number of consecutive cycles a grant may be held before forced release (legal range 1..2^HOLD_W-1).
- HOLD_W, 4: width of the hold counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  3  request lines; bit i = requester i.
- done  input  1  release strobe from the current owner; ignored when no grant is active.
- gnt  output  3  one-hot grant; 3'b000 when idle.
- gnt_idx  output  2  encoded owner (0, 1, 2); 2'b11 when idle.
- gnt_valid  output  1  high while a grant is active; equals |gnt.
- timeout  output  1  one-cycle pulse on the release cycle when the release was forced by MAX_HOLD.

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - state = IDLE; gnt = 000; gnt_idx = 11; gnt_valid = 0; timeout = 0; hold_cnt = 0.
  - last = 2, so requester 0 has first priority after reset.
- All outputs are registered; there is no combinational path from req or done to the outputs.
- State machine:
  - IDLE: if req != 0, select the first set bit scanning last+1, last+2, last+3 (mod 3). Register gnt/gnt_idx/gnt_valid and clear hold_cnt. Next state is GRANT. Latency is 1 cycle from req sampled to gnt visible. If req == 0, stay in IDLE.
  - GRANT: the owner is held. Each cycle in GRANT, evaluate release in this priority order:
    - a) done = 1, or b) req[owner] = 0: release, timeout = 0.
    - c) hold_cnt == MAX_HOLD-1: release, timeout = 1.
    - On release: last <= owner, outputs return to idle values, next state is IDLE.
    - Otherwise hold_cnt increments.
- A grant therefore lasts at most MAX_HOLD cycles.
- A released requester is never re-granted in the cycle after release. There is always exactly one idle cycle between grants (gnt_valid low for one cycle).
- Simultaneous events:
  - done and timeout condition in the same cycle: treated as a normal release, timeout = 0.
  - done together with req changes of other requesters: the new arbitration happens in the following IDLE cycle using updated req and last.
- Fairness: with all three requesters continuously requesting, grant order is 0,1,2,0,1,2… Each grant lasts until done or timeout.
- Changes on non-owner req bits during GRANT have no effect.
- Reset mid-grant: the next edge forces the reset values, the grant drops immediately, and last returns to 2.
- MAX_HOLD = 1: every grant is exactly 1 cycle and times out unless done is seen in that cycle.

Decomposition:
- Shared include file (enc_arb_defs.vh):
  - state encodings ST_IDLE = 1'b0, ST_GRANT = 1'b1.
  - IDX_NONE = 2'b11.
  - requester count NREQ = 3.
- One sub-module, enc_rr_pick3 (combinational):
  - inputs req[2:0] and last[1:0].
  - outputs pick_valid and pick_idx[1:0] / pick_onehot[2:0].
  - performs the rotated priority encode.
  - The top block owns the FSM, hold counter, last pointer and output registers.

Test Plan:
- Reset: assert rst 2 cycles with req = 111 → gnt = 000, gnt_idx = 11, gnt_valid = 0, timeout = 0 throughout. Release rst → gnt = 001, idx = 0 one cycle later.
- Single requester: req = 010 → gnt = 010, idx = 1 after 1 cycle. Pulse done for 1 cycle on the 3rd grant cycle → gnt = 000 next cycle, timeout = 0. With req still 010, re-granted after exactly one idle cycle.
- Round robin: req = 111, owner pulses done after 2 grant cycles → grant sequence idx 0,1,2,0 with one idle cycle between each.
- Timeout: MAX_HOLD = 15, req = 100 held, done never asserted → gnt = 100 for exactly 15 cycles. timeout = 1 on the cycle gnt drops to 000, then timeout = 0.
- Request drop and simultaneity: owner 0 deasserts req[0] while req = 110 → release, next grant goes to idx 1. Separately, assert done on the cycle hold_cnt == MAX_HOLD-1 → release with timeout = 0.
- Reset mid-grant: owner 1 holding, assert rst → next cycle gnt = 000, idx = 11. After release with req = 011, grant goes to idx 0 (last reset to 2).

Source files
------------

// File: rtl/enc_rr_arbiter3_pkg.sv
// Shared definitions for the three-way round-robin arbiter: FSM states,
// idle index code and the index-to-one-hot helper.
package enc_rr_arbiter3_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [1:0] IDX_NONE = 2'b11;
    localparam int         NREQ     = 3;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NREQ-1:0] oh;
        oh = 3'b000;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/enc_rr_arbiter3_pick3.sv
// Rotated priority encoder: picks the first requester after 'last',
// wrapping modulo three.
module enc_rr_pick3
    import enc_rr_arbiter3_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic       pick_valid,
    output logic [1:0] pick_idx,
    output logic [2:0] pick_onehot
);

    logic [1:0] first_s;
    logic [1:0] second_s;
    logic [1:0] third_s;

    // Scan order starting just after the previous owner
    always_comb begin
        first_s  = 2'd0;
        second_s = 2'd1;
        third_s  = 2'd2;
        case (last)
            2'd0: begin
                first_s  = 2'd1;
                second_s = 2'd2;
                third_s  = 2'd0;
            end
            2'd1: begin
                first_s  = 2'd2;
                second_s = 2'd0;
                third_s  = 2'd1;
            end
            default: begin
                first_s  = 2'd0;
                second_s = 2'd1;
                third_s  = 2'd2;
            end
        endcase
    end

    // Take the first active request in scan order
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = IDX_NONE;
        if (req[first_s]) begin
            pick_valid = 1'b1;
            pick_idx   = first_s;
        end else if (req[second_s]) begin
            pick_valid = 1'b1;
            pick_idx   = second_s;
        end else if (req[third_s]) begin
            pick_valid = 1'b1;
            pick_idx   = third_s;
        end else begin
            pick_valid = 1'b0;
            pick_idx   = IDX_NONE;
        end
    end

    assign pick_onehot = idx_to_onehot(pick_idx);

endmodule

// File: rtl/enc_rr_arbiter3.sv
// Three-requester round-robin arbiter with grant hold, explicit release and
// a hold timeout; all outputs come straight from registers.
module enc_rr_arbiter3
    import enc_rr_arbiter3_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};

    state_e            state_r;
    logic [1:0]        last_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [2:0]        gnt_r;
    logic [1:0]        gnt_idx_r;
    logic              gnt_valid_r;
    logic              timeout_r;

    logic              pick_valid_s;
    logic [1:0]        pick_idx_s;
    logic [2:0]        pick_onehot_s;
    logic              owner_req_s;
    logic              at_limit_s;

    enc_rr_pick3 u_pick (
        .req         (req),
        .last        (last_r),
        .pick_valid  (pick_valid_s),
        .pick_idx    (pick_idx_s),
        .pick_onehot (pick_onehot_s)
    );

    // The owner is still requesting when its one-hot bit meets req
    assign owner_req_s = |(req & gnt_r);
    assign at_limit_s  = (hold_cnt_r == HOLD_LAST);

    // Arbitration FSM, hold counter, last-owner pointer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_r      <= 2'd2;
            hold_cnt_r  <= HOLD_ZERO;
            gnt_r       <= 3'b000;
            gnt_idx_r   <= IDX_NONE;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    timeout_r  <= 1'b0;
                    hold_cnt_r <= HOLD_ZERO;
                    if (pick_valid_s) begin
                        gnt_r       <= pick_onehot_s;
                        gnt_idx_r   <= pick_idx_s;
                        gnt_valid_r <= 1'b1;
                        state_r     <= ST_GRANT;
                    end else begin
                        gnt_r       <= 3'b000;
                        gnt_idx_r   <= IDX_NONE;
                        gnt_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    // Voluntary release wins over the timeout in the same cycle
                    if (done || !owner_req_s) begin
                        last_r      <= gnt_idx_r;
                        gnt_r       <= 3'b000;
                        gnt_idx_r   <= IDX_NONE;
                        gnt_valid_r <= 1'b0;
                        timeout_r   <= 1'b0;
                        hold_cnt_r  <= HOLD_ZERO;
                        state_r     <= ST_IDLE;
                    end else if (at_limit_s) begin
                        last_r      <= gnt_idx_r;
                        gnt_r       <= 3'b000;
                        gnt_idx_r   <= IDX_NONE;
                        gnt_valid_r <= 1'b0;
                        timeout_r   <= 1'b1;
                        hold_cnt_r  <= HOLD_ZERO;
                        state_r     <= ST_IDLE;
                    end else begin
                        hold_cnt_r  <= hold_cnt_r + HOLD_ONE;
                        timeout_r   <= 1'b0;
                        state_r     <= ST_GRANT;
                    end
                end
                default: begin
                    gnt_r       <= 3'b000;
                    gnt_idx_r   <= IDX_NONE;
                    gnt_valid_r <= 1'b0;
                    timeout_r   <= 1'b0;
                    hold_cnt_r  <= HOLD_ZERO;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign gnt_idx   = gnt_idx_r;
    assign gnt_valid = gnt_valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_enc_rr_arbiter3.sv
// Self-checking bench for enc_rr_arbiter3: directed scenarios with literal
// expectations plus a randomized run against a behavioural owner/last model.
module tb_enc_rr_arbiter3;

    localparam int MAX_HOLD = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       done;
    logic [2:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    always #5 clk = ~clk;

    enc_rr_arbiter3 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner (-1 when idle), cycles the grant has been visible,
    // last owner and the timeout flag that is visible after this edge.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 2;
    bit m_to    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 2;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                if (m_owner < 0 && req[(m_last + k) % 3]) begin
                    m_owner = (m_last + k) % 3;
                    m_held  = 1;
                end
            end
        end else if (done || !req[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
            m_to    = 1'b0;
        end else if (m_held == MAX_HOLD) begin
            m_last  = m_owner;
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model
    task automatic tick();
        logic [2:0] e_gnt;
        logic [1:0] e_idx;
        @(negedge clk);
        e_gnt = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
        e_idx = (m_owner >= 0) ? 2'(m_owner) : 2'b11;
        chk("model_gnt", {29'd0, gnt}, {29'd0, e_gnt});
        chk("model_idx", {30'd0, gnt_idx}, {30'd0, e_idx});
        chk("model_valid", {31'd0, gnt_valid}, {31'd0, (m_owner >= 0)});
        chk("model_timeout", {31'd0, timeout}, {31'd0, m_to});
    endtask

    initial begin
        int cnt;

        // Reset held with all requests active
        rst  = 1'b1;
        req  = 3'b111;
        done = 1'b0;
        tick();
        chk("rst_gnt", {29'd0, gnt}, 32'h0);
        chk("rst_idx", {30'd0, gnt_idx}, 32'h3);
        tick();
        chk("rst_valid", {31'd0, gnt_valid}, 32'h0);
        chk("rst_timeout", {31'd0, timeout}, 32'h0);
        rst = 1'b0;
        tick();
        chk("first_gnt", {29'd0, gnt}, 32'h1);
        chk("first_idx", {30'd0, gnt_idx}, 32'h0);
        req = 3'b000;
        tick();
        chk("drop_gnt", {29'd0, gnt}, 32'h0);

        // Single requester, done on the third grant cycle
        req = 3'b010;
        tick();
        chk("single_gnt", {29'd0, gnt}, 32'h2);
        chk("single_idx", {30'd0, gnt_idx}, 32'h1);
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("single_rel", {29'd0, gnt}, 32'h0);
        chk("single_rel_to", {31'd0, timeout}, 32'h0);
        tick();
        chk("single_regrant", {29'd0, gnt}, 32'h2);
        done = 1'b1;
        tick();
        done = 1'b0;

        // Round robin from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_idx", {30'd0, gnt_idx}, i % 3);
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            chk("rr_gap", {31'd0, gnt_valid}, 32'h0);
        end

        // Forced release after MAX_HOLD cycles
        req = 3'b100;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (gnt == 3'b100) cnt++;
            else break;
        end
        chk("timeout_len", cnt, MAX_HOLD);
        chk("timeout_pulse", {31'd0, timeout}, 32'h1);
        tick();
        chk("timeout_clear", {31'd0, timeout}, 32'h0);
        chk("timeout_regrant", {29'd0, gnt}, 32'h4);
        req = 3'b000;
        tick();

        // Owner drops its request; next grant goes to requester 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 3'b111;
        tick();
        chk("drop_owner0", {30'd0, gnt_idx}, 32'h0);
        req = 3'b110;
        tick();
        chk("drop_release", {29'd0, gnt}, 32'h0);
        tick();
        chk("drop_next", {30'd0, gnt_idx}, 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;

        // done coincides with the last allowed hold cycle
        req = 3'b100;
        tick();
        repeat (MAX_HOLD - 1) tick();
        chk("limit_still", {29'd0, gnt}, 32'h4);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("limit_rel", {29'd0, gnt}, 32'h0);
        chk("limit_to", {31'd0, timeout}, 32'h0);
        req = 3'b000;
        tick();

        // Reset in the middle of a grant
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 3'b010;
        tick();
        chk("mid_owner", {30'd0, gnt_idx}, 32'h1);
        rst = 1'b1;
        tick();
        chk("mid_gnt", {29'd0, gnt}, 32'h0);
        chk("mid_idx", {30'd0, gnt_idx}, 32'h3);
        rst = 1'b0;
        req = 3'b011;
        tick();
        chk("mid_after", {29'd0, gnt}, 32'h1);

        // Randomized traffic against the model
        repeat (3000) begin
            rst  = ($urandom_range(0, 199) == 0);
            done = ($urandom_range(0, 9) == 0);
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
